// File: rtl/down_counter_pkg.sv
// rtl/down_counter_pkg.sv - FSM state encoding and width helpers for down_counter
package down_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    // All-ones value of a w-bit counter, i.e. the free-running wrap target.
    function automatic logic [31:0] CNT_MAX(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/Nbit_decrementer.sv
// rtl/Nbit_decrementer.sv - W-bit ripple-borrow decrementer, Diff = Count - En
module Nbit_decrementer #(
    parameter int W = 3
) (
    output logic [W-1:0] Diff,
    output logic         BorrowOut,
    input  logic [W-1:0] Count,
    input  logic         En
);

    // borrow[0] is the chain input; borrow[W] falls out only when Count==0 and En=1.
    logic [W:0] borrow;

    assign borrow[0] = En;

    for (genvar i = 0; i < W; i++) begin : g_stage
        half_subtractor u_hs (
            .A    (Count[i]),
            .B    (borrow[i]),
            .D    (Diff[i]),
            .Bout (borrow[i+1])
        );
    end

    assign BorrowOut = borrow[W];

endmodule

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - single-bit half subtractor, D = A - B with borrow-out
module half_subtractor (
    input  logic A,
    input  logic B,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B;
    assign Bout = ~A & B;

endmodule

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable down counter with one-shot/free-running FSM
// Optional macro DOWN_COUNTER_RELOAD_EN: free-running underflow reloads the last LdVal.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         En,
    input  logic         Ld,
    input  logic [W-1:0] LdVal,
    input  logic         OneShot,
    output logic [W-1:0] Count,
    output logic         Borrow,
    output logic         Zero,
    output logic         Expired
);

    localparam logic [W-1:0] WRAP_VAL = W'(CNT_MAX(W));

    state_t       state_q;
    logic [W-1:0] count_q;
    logic         expired_q;
    logic [W-1:0] diff;
    logic         chain_borrow;
    logic [W-1:0] wrap_d;

    Nbit_decrementer #(.W(W)) u_dec (
        .Diff      (diff),
        .BorrowOut (chain_borrow),
        .Count     (count_q),
        .En        (En)
    );

`ifdef DOWN_COUNTER_RELOAD_EN
    logic [W-1:0] reload_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            reload_q <= '0;
        end else if (Ld) begin
            reload_q <= LdVal;
        end
    end

    assign wrap_d = reload_q;
`else
    assign wrap_d = WRAP_VAL;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            expired_q <= 1'b0;
        end else if (Ld) begin
            state_q   <= ST_RUN;
            count_q   <= LdVal;
            expired_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    expired_q <= 1'b0;
                end
                ST_RUN: begin
                    if (En) begin
                        if (chain_borrow) begin
                            // OneShot matters only here, on the underflow edge.
                            if (OneShot) begin
                                state_q   <= ST_EXPIRED;
                                expired_q <= 1'b1;
                            end else begin
                                count_q <= wrap_d;
                            end
                        end else begin
                            count_q <= diff;
                        end
                    end
                end
                ST_EXPIRED: begin
                    count_q   <= '0;
                    expired_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    expired_q <= 1'b0;
                end
            endcase
        end
    end

    assign Count   = count_q;
    assign Zero    = (count_q == '0);
    assign Expired = expired_q;
    assign Borrow  = (state_q == ST_RUN) & ~Ld & chain_borrow;

endmodule
